rv32_control_fsm: RTL and testbench
===================================

Name: rv32_control_fsm

Overview:
- Multi-cycle RV32I control unit that drives the ALU: decodes the current instruction into `alu_control_t` plus datapath selects and write strobes.
- Sequences fetch, decode, execute, memory and writeback over a single-port memory with a req/ready handshake.
- Consumes the ALU condition bit (`alu_result[0]`) to resolve branches.
- Sits between the instruction register, register file, PC register and memory port of the multi-cycle core.

Parameters:
COUNT_WIDTH, 32, width of retired-instruction counter (wraps to 0 after all-ones).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr  in  32  instruction register contents (valid from DECODE onward)
alu_cond  in  1  bit 0 of ALU result
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request
mem_we  out  1  store request (valid with mem_req)
mem_addr_sel  out  1  0=PC, 1=ALU output register
mem_funct3  out  3  instr[14:12] passed through during MEM
ir_we  out  1  load instruction register
alu_control  out  alu_control_t  ALU operation (types package)
alu_src1_sel  out  2  0=rs1, 1=PC, 2=zero
alu_src2_sel  out  2  0=rs2, 1=imm, 2=const 4
pc_we  out  1  update PC
pc_sel  out  2  0=PC+4, 1=PC+imm, 2=ALU output with bit0 cleared
rf_we  out  1  register file write
wb_sel  out  2  0=ALU output, 1=memory data, 2=PC+4
retire_count  out  COUNT_WIDTH  retired instructions
illegal  out  1  sticky trap flag

Behaviour:
- Reset: state=FETCH, retire_count=0, illegal=0. All strobes (mem_req, mem_we, ir_we, pc_we, rf_we) are 0 in the reset cycle. Selects default to 0 and alu_control to ALU_ADD whenever not specified below. `rst` mid-operation aborts any memory request the next cycle.
- FETCH:
  - mem_req=1, mem_addr_sel=0, held until mem_ready.
  - mem_ready=1: ir_we=1, go to DECODE.
  - mem_ready is ignored when mem_req=0.
- DECODE (1 cycle):
  - Classify opcode.
  - Illegal encoding goes to TRAP. Illegal means:
    - unknown opcode or SYSTEM;
    - R-type funct7 not 0x00/0x20, or 0x20 with funct3 not 000/101;
    - I-type shift with bad funct7;
    - branch funct3 010/011;
    - load funct3 011/110/111;
    - store funct3 >010.
  - Otherwise go to EXECUTE.
- EXECUTE (1 cycle):
  - R/I ALU ops:
    - funct3 000→ADD (SUB if R and funct7=0x20); 001→SLL; 010→SLT; 011→SLTU; 100→XOR; 101→SRL/SRA by funct7[5]; 110→OR; 111→AND.
    - src2 = rs2 (R) or imm (I). Go to WRITEBACK.
  - LUI: src1=zero, src2=imm, ADD → WRITEBACK.
  - AUIPC: src1=PC, src2=imm, ADD → WRITEBACK.
  - LOAD/STORE: ADD rs1+imm → MEM.
  - BRANCH:
    - funct3 000/001/100/101/110/111 maps to BEQ/BNE/BLT/BGE/BLTU/BGEU.
    - pc_we=1; pc_sel=1 if alu_cond else 0.
    - retire; go to FETCH.
  - JAL: pc_we=1, pc_sel=1 → WRITEBACK.
  - JALR: ADD rs1+imm, pc_we=1, pc_sel=2 → WRITEBACK.
  - FENCE: pc_we=1, pc_sel=0, retire, go to FETCH (no-op).
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=store, mem_funct3=funct3; held until mem_ready.
  - On ready, load goes to WRITEBACK.
  - On ready, store sets pc_we=1, pc_sel=0, retires, goes to FETCH.
- WRITEBACK (1 cycle):
  - rf_we=1 unless rd (instr[11:7])=0.
  - wb_sel: 1 for load, 2 for JAL/JALR, 0 otherwise.
  - pc_we=1 with pc_sel=0, except JAL/JALR (PC already updated).
  - Retire; go to FETCH.
- Retire: retire_count increments by 1 on the cycle the instruction leaves for FETCH.
- TRAP: illegal=1; all strobes 0; exit only via rst.
- Zero-wait latencies: ALU/LUI/AUIPC/JAL/JALR 4 cycles, branch/FENCE 3, store 4, load 5. Each memory wait cycle adds 1.

Test Plan:
- `add x3,x1,x2` (0x002081B3), mem_ready=1 → states FETCH,DECODE,EXECUTE,WRITEBACK. EXECUTE: alu_control=ALU_ADD, src2_sel=0. WB: rf_we=1, wb_sel=0, pc_we=1, pc_sel=0. retire_count 0→1.
- 0x402081B3 → ALU_SUB. 0x4030D093 (`srai x1,x1,3`) → ALU_SRA with src2_sel=1.
- `beq x1,x2,8` (0x00208463): alu_cond=1 → EXECUTE pc_we=1, pc_sel=1, no rf_we, 3 cycles. alu_cond=0 → pc_sel=0.
- `lw x5,4(x1)` (0x0040A283), mem_ready low 2 cycles in MEM → mem_req held 3 cycles, mem_we=0, mem_funct3=010. WB: wb_sel=1, rf_we=1. Total 7 cycles.
- `sw x5,8(x1)` (0x0050A423) → MEM with mem_we=1, no rf_we, FETCH after ready. Same store with rd-field 0 behaves identically.
- 0x00000000 → TRAP, illegal=1, strobes stay 0 for 10 cycles. retire_count unchanged. rst → FETCH, illegal=0, count=0.

Source files
------------

// File: rtl/rv32_control_fsm.sv
// rtl/rv32_control_fsm.sv - multi-cycle RV32I control FSM driving ALU, memory port, PC and register file
package rv32_types_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_BEQ  = 4'd10,
    ALU_BNE  = 4'd11,
    ALU_BLT  = 4'd12,
    ALU_BGE  = 4'd13,
    ALU_BLTU = 4'd14,
    ALU_BGEU = 4'd15
  } alu_control_t;
endpackage

module rv32_control_fsm #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   instr,
  input  logic                          alu_cond,
  input  logic                          mem_ready,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic                          mem_addr_sel,
  output logic [2:0]                    mem_funct3,
  output logic                          ir_we,
  output rv32_types_pkg::alu_control_t  alu_control,
  output logic [1:0]                    alu_src1_sel,
  output logic [1:0]                    alu_src2_sel,
  output logic                          pc_we,
  output logic [1:0]                    pc_sel,
  output logic                          rf_we,
  output logic [1:0]                    wb_sel,
  output logic [COUNT_WIDTH-1:0]        retire_count,
  output logic                          illegal
);
  import rv32_types_pkg::*;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  state_t state, state_next;
  logic   retire;
  logic   bad_instr;
  alu_control_t arith_op, branch_op;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       is_store, is_jump;
  logic       unused_reg_fields;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rd       = instr[11:7];
  assign is_store = (opcode == OP_STORE);
  assign is_jump  = (opcode == OP_JAL) || (opcode == OP_JALR);
  // Register specifiers are consumed by the register file, not by control.
  assign unused_reg_fields = ^instr[24:15];

  always_comb begin
    bad_instr = 1'b0;
    case (opcode)
      OP_REG: begin
        if (funct7 == 7'h20) bad_instr = !(funct3 == 3'b000 || funct3 == 3'b101);
        else if (funct7 != 7'h00) bad_instr = 1'b1;
      end
      OP_IMM: begin
        if (funct3 == 3'b001 && funct7 != 7'h00) bad_instr = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20) bad_instr = 1'b1;
      end
      OP_BRANCH: bad_instr = (funct3 == 3'b010) || (funct3 == 3'b011);
      OP_LOAD:   bad_instr = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      OP_STORE:  bad_instr = (funct3 > 3'b010);
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_FENCE: bad_instr = 1'b0;
      default:   bad_instr = 1'b1;
    endcase
  end

  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      3'b000: arith_op = (opcode == OP_REG && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001: arith_op = ALU_SLL;
      3'b010: arith_op = ALU_SLT;
      3'b011: arith_op = ALU_SLTU;
      3'b100: arith_op = ALU_XOR;
      3'b101: arith_op = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110: arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  always_comb begin
    branch_op = ALU_BEQ;
    case (funct3)
      3'b001:  branch_op = ALU_BNE;
      3'b100:  branch_op = ALU_BLT;
      3'b101:  branch_op = ALU_BGE;
      3'b110:  branch_op = ALU_BLTU;
      3'b111:  branch_op = ALU_BGEU;
      default: branch_op = ALU_BEQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      retire_count <= '0;
      illegal      <= 1'b0;
    end else begin
      state <= state_next;
      if (retire) retire_count <= retire_count + COUNT_WIDTH'(1);
      if (state_next == S_TRAP) illegal <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    mem_funct3   = 3'b000;
    ir_we        = 1'b0;
    alu_control  = ALU_ADD;
    alu_src1_sel = 2'd0;
    alu_src2_sel = 2'd0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = bad_instr ? S_TRAP : S_EXECUTE;
      S_EXECUTE: begin
        case (opcode)
          OP_REG: begin
            alu_control = arith_op;
            state_next  = S_WRITEBACK;
          end
          OP_IMM: begin
            alu_control  = arith_op;
            alu_src2_sel = 2'd1;
            state_next   = S_WRITEBACK;
          end
          OP_LUI: begin
            alu_src1_sel = 2'd2;
            alu_src2_sel = 2'd1;
            state_next   = S_WRITEBACK;
          end
          OP_AUIPC: begin
            alu_src1_sel = 2'd1;
            alu_src2_sel = 2'd1;
            state_next   = S_WRITEBACK;
          end
          OP_LOAD, OP_STORE: begin
            alu_src2_sel = 2'd1;
            state_next   = S_MEM;
          end
          OP_BRANCH: begin
            alu_control = branch_op;
            pc_we       = 1'b1;
            pc_sel      = alu_cond ? 2'd1 : 2'd0;
            retire      = 1'b1;
            state_next  = S_FETCH;
          end
          OP_JAL: begin
            pc_we      = 1'b1;
            pc_sel     = 2'd1;
            state_next = S_WRITEBACK;
          end
          OP_JALR: begin
            alu_src2_sel = 2'd1;
            pc_we        = 1'b1;
            pc_sel       = 2'd2;
            state_next   = S_WRITEBACK;
          end
          OP_FENCE: begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          default: state_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        mem_funct3   = funct3;
        if (mem_ready) begin
          if (is_store) begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        rf_we      = (rd != 5'd0);
        wb_sel     = (opcode == OP_LOAD) ? 2'd1 : (is_jump ? 2'd2 : 2'd0);
        // Jumps already redirected the PC in EXECUTE.
        pc_we      = !is_jump;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_TRAP;
    endcase

    // The reset cycle presents an idle port so any in-flight request is dropped.
    if (rst) begin
      retire       = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      mem_funct3   = 3'b000;
      ir_we        = 1'b0;
      alu_control  = ALU_ADD;
      alu_src1_sel = 2'd0;
      alu_src2_sel = 2'd0;
      pc_we        = 1'b0;
      pc_sel       = 2'd0;
      rf_we        = 1'b0;
      wb_sel       = 2'd0;
    end
  end
endmodule

// File: tb/tb_rv32_control_fsm.sv
// tb/tb_rv32_control_fsm.sv - scoreboard bench for rv32_control_fsm
module tb_rv32_control_fsm;
  import rv32_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        alu_cond = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, illegal;
  logic [2:0]  mem_funct3;
  alu_control_t alu_control;
  logic [1:0]  alu_src1_sel, alu_src2_sel, pc_sel, wb_sel;
  logic [31:0] retire_count;

  rv32_control_fsm #(.COUNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_cond(alu_cond), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .mem_funct3(mem_funct3),
    .ir_we(ir_we), .alu_control(alu_control), .alu_src1_sel(alu_src1_sel),
    .alu_src2_sel(alu_src2_sel), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .retire_count(retire_count), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         mem_req;
    logic         mem_we;
    logic         mem_addr_sel;
    logic [2:0]   mem_funct3;
    logic         ir_we;
    alu_control_t alu;
    logic [1:0]   src1;
    logic [1:0]   src2;
    logic         pc_we;
    logic [1:0]   pc_sel;
    logic         rf_we;
    logic [1:0]   wb_sel;
    logic         illegal;
    logic [31:0]  cnt;
  } obs_t;

  typedef struct {
    obs_t  v;
    string name;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] cnt = 0;
  logic        ill = 1'b0;
  logic [31:0] cur_instr = 32'h0;

  function automatic obs_t base();
    obs_t o;
    o = '0;
    o.alu = ALU_ADD;
    o.cnt = cnt;
    o.illegal = ill;
    return o;
  endfunction

  task automatic step(input logic r, input logic rdy, input logic cnd, input obs_t e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r;
    mem_ready = rdy;
    alu_cond = cnd;
    instr = cur_instr;
    x.v = e;
    x.name = nm;
    q.push_back(x);
  endtask

  task automatic t_fetch(input logic rdy);
    obs_t e;
    e = base();
    e.mem_req = 1'b1;
    e.ir_we = rdy;
    step(1'b0, rdy, 1'b0, e, "fetch");
  endtask

  task automatic t_dec();
    step(1'b0, 1'b0, 1'b0, base(), "decode");
  endtask

  task automatic t_ex(input alu_control_t op, input logic [1:0] s1, input logic [1:0] s2,
                      input logic pcwe, input logic [1:0] pcs, input logic cnd);
    obs_t e;
    e = base();
    e.alu = op;
    e.src1 = s1;
    e.src2 = s2;
    e.pc_we = pcwe;
    e.pc_sel = pcs;
    step(1'b0, 1'b0, cnd, e, "execute");
  endtask

  task automatic t_mem(input logic we, input logic [2:0] f3, input logic rdy, input logic pcwe);
    obs_t e;
    e = base();
    e.mem_req = 1'b1;
    e.mem_addr_sel = 1'b1;
    e.mem_we = we;
    e.mem_funct3 = f3;
    e.pc_we = pcwe;
    step(1'b0, rdy, 1'b0, e, "mem");
  endtask

  task automatic t_wb(input logic rfwe, input logic [1:0] wbs, input logic pcwe);
    obs_t e;
    e = base();
    e.rf_we = rfwe;
    e.wb_sel = wbs;
    e.pc_we = pcwe;
    step(1'b0, 1'b0, 1'b0, e, "writeback");
  endtask

  // Monitor: every sampled cycle with a pending expectation is scored.
  always @(negedge clk) begin
    exp_t e;
    obs_t a;
    if (q.size() != 0) begin
      e = q.pop_front();
      a.mem_req = mem_req;
      a.mem_we = mem_we;
      a.mem_addr_sel = mem_addr_sel;
      a.mem_funct3 = mem_funct3;
      a.ir_we = ir_we;
      a.alu = alu_control;
      a.src1 = alu_src1_sel;
      a.src2 = alu_src2_sel;
      a.pc_we = pc_we;
      a.pc_sel = pc_sel;
      a.rf_we = rf_we;
      a.wb_sel = wb_sel;
      a.illegal = illegal;
      a.cnt = retire_count;
      tests++;
      if (a !== e.v) begin
        fails++;
        $display("FAIL %s instr=%h: got %h want %h", e.name, instr, a, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    @(posedge clk);
    step(1'b1, 1'b0, 1'b0, base(), "reset");

    cur_instr = 32'h002081B3; // add x3,x1,x2
    t_fetch(1); t_dec(); t_ex(ALU_ADD, 0, 0, 0, 0, 0); t_wb(1, 0, 1); cnt++;

    cur_instr = 32'h402081B3; // sub, one fetch wait
    t_fetch(0); t_fetch(1); t_dec(); t_ex(ALU_SUB, 0, 0, 0, 0, 0); t_wb(1, 0, 1); cnt++;

    cur_instr = 32'h4030D093; // srai x1,x1,3
    t_fetch(1); t_dec(); t_ex(ALU_SRA, 0, 1, 0, 0, 0); t_wb(1, 0, 1); cnt++;

    cur_instr = 32'h00208463; // beq taken
    t_fetch(1); t_dec(); t_ex(ALU_BEQ, 0, 0, 1, 1, 1); cnt++;
    t_fetch(1); t_dec(); t_ex(ALU_BEQ, 0, 0, 1, 0, 0); cnt++;

    cur_instr = 32'h0040A283; // lw x5,4(x1), two memory waits
    t_fetch(1); t_dec(); t_ex(ALU_ADD, 0, 1, 0, 0, 0);
    t_mem(0, 3'b010, 0, 0); t_mem(0, 3'b010, 0, 0); t_mem(0, 3'b010, 1, 0);
    t_wb(1, 1, 1); cnt++;

    cur_instr = 32'h0050A423; // sw x5,8(x1)
    t_fetch(1); t_dec(); t_ex(ALU_ADD, 0, 1, 0, 0, 0); t_mem(1, 3'b010, 1, 1); cnt++;

    cur_instr = 32'h0050A023; // same store, rd field zero
    t_fetch(1); t_dec(); t_ex(ALU_ADD, 0, 1, 0, 0, 0); t_mem(1, 3'b010, 1, 1); cnt++;

    cur_instr = 32'h008000EF; // jal x1,8
    t_fetch(1); t_dec(); t_ex(ALU_ADD, 0, 0, 1, 1, 0); t_wb(1, 2, 0); cnt++;

    cur_instr = 32'h12345037; // lui x0
    t_fetch(1); t_dec(); t_ex(ALU_ADD, 2, 1, 0, 0, 0); t_wb(0, 0, 1); cnt++;

    cur_instr = 32'h0000000F; // fence
    t_fetch(1); t_dec(); t_ex(ALU_ADD, 0, 0, 1, 0, 0); cnt++;

    cur_instr = 32'h000080E7; // jalr x1,0(x1)
    t_fetch(1); t_dec(); t_ex(ALU_ADD, 0, 1, 1, 2, 0); t_wb(1, 2, 0); cnt++;

    cur_instr = 32'h00000000; // illegal
    t_fetch(1); t_dec();
    ill = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, base(), "trap");
    step(1'b1, 1'b0, 1'b0, base(), "rst_after_trap");
    ill = 1'b0;
    cnt = 0;

    cur_instr = 32'h0040A283; // load aborted by reset while waiting in MEM
    t_fetch(1); t_dec(); t_ex(ALU_ADD, 0, 1, 0, 0, 0); t_mem(0, 3'b010, 0, 0);
    step(1'b1, 1'b0, 1'b0, base(), "rst_mid_mem");

    cur_instr = 32'h002081B3;
    t_fetch(1); t_dec(); t_ex(ALU_ADD, 0, 0, 0, 0, 0); t_wb(1, 0, 1); cnt++;

    cur_instr = 32'h402091B3; // funct7 0x20 with funct3 001
    t_fetch(1); t_dec();
    ill = 1'b1;
    step(1'b0, 1'b0, 1'b0, base(), "trap_rtype");
    step(1'b0, 1'b0, 1'b0, base(), "trap_rtype");

    @(posedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
